// File: rtl/i2c_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_cfg_pkg
//  Description : Shared types and constants for the I2C command arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_cfg_pkg;

    localparam int I2C_CMD_W = 24;

    // Command field positions: {slave_addr, sub_addr, data}
    localparam int CMD_SLAVE_MSB = 23;
    localparam int CMD_SLAVE_LSB = 16;
    localparam int CMD_SUB_MSB   = 15;
    localparam int CMD_SUB_LSB   = 8;
    localparam int CMD_DATA_MSB  = 7;
    localparam int CMD_DATA_LSB  = 0;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        WAIT_END = 3'd2,
        RELEASE  = 3'd3,
        GAP      = 3'd4
    } arbState_t;

    typedef enum logic [1:0] {
        OK      = 2'd0,
        NACK    = 2'd1,
        TIMEOUT = 2'd2
    } outcome_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin pick; first request at or after
//                the pointer, wrapping, as one-hot grant plus index.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!o_valid && i_req[(int'(i_ptr) + i) % N_REQ]) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'((int'(i_ptr) + i) % N_REQ);
                o_gnt[(int'(i_ptr) + i) % N_REQ] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2c_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_cmd_arbiter
//  Description : Round-robin sharing of one I2C byte engine between several
//                configuration sequencers, with NACK retry and hang timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_cmd_arbiter
    import i2c_cfg_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int MAX_RETRY   = 3,
    parameter int TIMEOUT_CYC = 65535,
    parameter int GAP_CYC     = 16
) (
    input  logic                       iCLK,
    input  logic                       iRST,
    input  logic [N_REQ-1:0]           iREQ,
    input  logic [I2C_CMD_W*N_REQ-1:0] iREQ_DATA,
    output logic [N_REQ-1:0]           oGNT,
    output logic [N_REQ-1:0]           oDONE,
    output logic [N_REQ-1:0]           oERR,
    output logic                       oBUSY,
    output logic [I2C_CMD_W-1:0]       oENG_DATA,
    output logic                       oENG_GO,
    input  logic                       iENG_END,
    input  logic                       iENG_ACK
);

    localparam int c_IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int c_TMO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam int c_GAP_W   = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam int c_RETRY_W = $clog2(MAX_RETRY + 1);

    arbState_t              r_state;
    outcome_t               r_outcome;
    logic [c_IDX_W-1:0]     r_ptr;
    logic [c_IDX_W-1:0]     r_gntIdx;
    logic [c_TMO_W-1:0]     r_tmo;
    logic [c_GAP_W-1:0]     r_gap;
    logic [c_RETRY_W-1:0]   r_retry;

    logic [I2C_CMD_W-1:0]   w_reqData [N_REQ];
    logic [N_REQ-1:0]       w_pickGnt;
    logic [c_IDX_W-1:0]     w_pickIdx;
    logic                   w_pickValid;
    logic [c_TMO_W-1:0]     w_tmoNext;
    logic                   w_retryLeft;
    logic [c_IDX_W-1:0]     w_ptrNext;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign w_reqData[gi] = iREQ_DATA[gi*I2C_CMD_W +: I2C_CMD_W];
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (c_IDX_W)
    ) u_rr (
        .i_req   (iREQ),
        .i_ptr   (r_ptr),
        .o_gnt   (w_pickGnt),
        .o_idx   (w_pickIdx),
        .o_valid (w_pickValid)
    );

    assign w_tmoNext   = r_tmo + c_TMO_W'(1);
    assign w_retryLeft = (int'(r_retry) + 1) < MAX_RETRY;
    assign w_ptrNext   = (int'(r_gntIdx) == N_REQ - 1) ? '0 : r_gntIdx + c_IDX_W'(1);
    assign oBUSY       = (r_state != IDLE);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state   <= IDLE;
            r_outcome <= OK;
            r_ptr     <= '0;
            r_gntIdx  <= '0;
            r_tmo     <= '0;
            r_gap     <= '0;
            r_retry   <= '0;
            oGNT      <= '0;
            oDONE     <= '0;
            oERR      <= '0;
            oENG_DATA <= '0;
            oENG_GO   <= 1'b0;
        end else begin
            oDONE <= '0;
            oERR  <= '0;
            case (r_state)
                IDLE: begin
                    if (w_pickValid) begin
                        oGNT      <= w_pickGnt;
                        r_gntIdx  <= w_pickIdx;
                        oENG_DATA <= w_reqData[w_pickIdx];
                        r_retry   <= '0;
                        r_state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    oENG_GO <= 1'b1;
                    r_tmo   <= '0;
                    r_state <= WAIT_END;
                end
                WAIT_END: begin
                    r_tmo <= w_tmoNext;
                    // END takes priority over a simultaneous timeout
                    if (iENG_END) begin
                        oENG_GO   <= 1'b0;
                        r_outcome <= iENG_ACK ? NACK : OK;
                        r_state   <= RELEASE;
                    end else if (w_tmoNext == c_TMO_W'(TIMEOUT_CYC)) begin
                        oENG_GO   <= 1'b0;
                        r_outcome <= TIMEOUT;
                        r_state   <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!iENG_END) begin
                        r_gap   <= c_GAP_W'(GAP_CYC);
                        r_state <= GAP;
                    end
                end
                GAP: begin
                    if (r_gap != '0) begin
                        r_gap <= r_gap - c_GAP_W'(1);
                    end else if (r_outcome == NACK && w_retryLeft) begin
                        r_retry <= r_retry + c_RETRY_W'(1);
                        r_state <= ISSUE;
                    end else begin
                        oDONE[r_gntIdx] <= 1'b1;
                        oERR[r_gntIdx]  <= (r_outcome != OK);
                        oGNT            <= '0;
                        r_ptr           <= w_ptrNext;
                        r_state         <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_cmd_arbiter
//  Description : Scoreboard bench with an engine model for i2c_cmd_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_i2c_cmd_arbiter;

    localparam int N    = 2;
    localparam int MAXR = 3;
    localparam int TMO  = 100;
    localparam int GAPC = 16;

    logic            iCLK = 1'b0;
    logic            iRST;
    logic [N-1:0]    iREQ;
    logic [24*N-1:0] iREQ_DATA;
    logic [N-1:0]    oGNT, oDONE, oERR;
    logic            oBUSY, oENG_GO, iENG_END, iENG_ACK;
    logic [23:0]     oENG_DATA;

    i2c_cmd_arbiter #(
        .N_REQ(N), .MAX_RETRY(MAXR), .TIMEOUT_CYC(TMO), .GAP_CYC(GAPC)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iREQ(iREQ), .iREQ_DATA(iREQ_DATA),
        .oGNT(oGNT), .oDONE(oDONE), .oERR(oERR), .oBUSY(oBUSY),
        .oENG_DATA(oENG_DATA), .oENG_GO(oENG_GO),
        .iENG_END(iENG_END), .iENG_ACK(iENG_ACK)
    );

    always #5 iCLK = ~iCLK;

    // kind: 0 ack, 1 nack, 2 hang (length checked), 3 hang (cut by reset)
    typedef struct { int req; logic [23:0] data; bit err; int attempts; } exp_t;
    typedef struct { int kind; int delay; } att_t;

    exp_t sb[$];
    att_t plan[$];
    int   total = 0;
    int   bad = 0;
    int   engAttempts = 0;
    int   idleCyc = 0;

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", name, got, exp, $time);
        end
    endtask

    // Reference: attempts stop at the first ack, at a hang, or after MAXR tries
    task automatic addCmd(int r, logic [23:0] d, int k0, int k1, int k2, int dly);
        int   ks[3];
        exp_t e;
        ks[0] = k0; ks[1] = k1; ks[2] = k2;
        e.req = r; e.data = d; e.err = 1'b1; e.attempts = 0;
        for (int a = 0; a < MAXR; a++) begin
            e.attempts = a + 1;
            plan.push_back('{kind: ks[a], delay: dly + a});
            if (ks[a] == 0) begin
                e.err = 1'b0;
                break;
            end
            if (ks[a] >= 2) break;
        end
        sb.push_back(e);
    endtask

    task automatic setData(int r, logic [23:0] d);
        iREQ_DATA[r*24 +: 24] = d;
    endtask

    task automatic waitDone(int r);
        int c = 0;
        do begin
            @(posedge iCLK); #1;
            c++;
        end while (!oDONE[r] && c < 3000);
        check("done_seen", oDONE[r], 1);
    endtask

    task automatic doReset();
        iRST = 1'b1;
        repeat (2) @(posedge iCLK);
        #1 iRST = 1'b0;
    endtask

    // Engine model
    initial begin
        iENG_END = 1'b0;
        iENG_ACK = 1'b0;
        forever begin
            @(posedge iCLK); #1;
            if (iRST || !oENG_GO) begin
                idleCyc++;
            end else begin
                att_t a;
                int   hi;
                if (engAttempts > 0) check("retry_gap", idleCyc >= GAPC, 1);
                engAttempts++;
                check("go_has_cmd", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    check("eng_data", oENG_DATA, sb[0].data);
                    check("eng_gnt", oGNT, 1 << sb[0].req);
                end
                if (plan.size() > 0) a = plan.pop_front();
                else begin a.kind = 0; a.delay = 1; end
                hi = 1;
                if (a.kind <= 1) begin
                    repeat (a.delay) begin @(posedge iCLK); #1; end
                    iENG_END = 1'b1;
                    iENG_ACK = (a.kind == 1);
                end
                for (int c = 0; c < 1000 && oENG_GO; c++) begin
                    @(posedge iCLK); #1;
                    if (oENG_GO) hi++;
                end
                check("go_dropped", oENG_GO, 0);
                if (a.kind == 2) check("timeout_len", hi, TMO);
                iENG_END = 1'b0;
                iENG_ACK = 1'b0;
                idleCyc  = 1;
            end
        end
    end

    // Completion monitor
    always @(negedge iCLK) begin
        if (iRST) begin
            sb.delete();
            plan.delete();
            engAttempts = 0;
        end else begin
            if ((oERR & ~oDONE) != '0) check("err_without_done", oERR & ~oDONE, 0);
            if (oDONE != '0) begin
                if (sb.size() == 0) begin
                    check("done_unexpected", oDONE, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_vec", oDONE, 1 << e.req);
                    check("err_vec", oERR, e.err ? (1 << e.req) : 0);
                    check("attempts", engAttempts, e.attempts);
                    check("gnt_cleared", oGNT, 0);
                    check("busy_cleared", oBUSY, 0);
                end
                engAttempts = 0;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] d0a, d0b, d1a, d1b, d;
        int          c;
        iRST = 1'b1; iREQ = '0; iREQ_DATA = '0;
        repeat (3) @(posedge iCLK); #1;
        check("rst_gnt", oGNT, 0);
        check("rst_done", oDONE, 0);
        check("rst_err", oERR, 0);
        check("rst_busy", oBUSY, 0);
        check("rst_go", oENG_GO, 0);
        check("rst_data", oENG_DATA, 0);
        iRST = 1'b0;

        // Single command with GO latency check
        addCmd(0, 24'h729803, 0, 0, 0, 40);
        setData(0, 24'h729803);
        iREQ[0] = 1'b1;
        @(posedge iCLK); #1;
        check("lat1_go", oENG_GO, 0);
        check("lat1_gnt", oGNT, 2'b01);
        check("lat1_busy", oBUSY, 1);
        @(posedge iCLK); #1;
        check("lat2_go", oENG_GO, 1);
        check("lat2_data", oENG_DATA, 24'h729803);
        waitDone(0);
        iREQ[0] = 1'b0;

        // Both requesters held: grants 0,1,0,1
        doReset();
        d0a = 24'($urandom); d0b = 24'($urandom);
        d1a = 24'($urandom); d1b = 24'($urandom);
        addCmd(0, d0a, 0, 0, 0, $urandom_range(1, 30));
        addCmd(1, d1a, 0, 0, 0, $urandom_range(1, 30));
        addCmd(0, d0b, 0, 0, 0, $urandom_range(1, 30));
        addCmd(1, d1b, 0, 0, 0, $urandom_range(1, 30));
        setData(0, d0a); setData(1, d1a);
        iREQ = 2'b11;
        waitDone(0); setData(0, d0b);
        waitDone(1); setData(1, d1b);
        waitDone(0); iREQ[0] = 1'b0;
        waitDone(1); iREQ[1] = 1'b0;

        // NACK on every attempt, then NACK followed by ACK
        d = 24'($urandom);
        addCmd(1, d, 1, 1, 1, $urandom_range(1, 30));
        setData(1, d); iREQ[1] = 1'b1;
        waitDone(1); iREQ[1] = 1'b0;
        d = 24'($urandom);
        addCmd(1, d, 1, 0, 0, $urandom_range(1, 30));
        setData(1, d); iREQ[1] = 1'b1;
        waitDone(1); iREQ[1] = 1'b0;

        // Engine hang, no retry
        d = 24'($urandom);
        addCmd(0, d, 2, 0, 0, 1);
        setData(0, d); iREQ[0] = 1'b1;
        waitDone(0); iREQ[0] = 1'b0;

        // Reset in WAIT_END, then a pending request from requester 1
        d = 24'($urandom);
        addCmd(0, d, 3, 0, 0, 1);
        setData(0, d); iREQ[0] = 1'b1;
        c = 0;
        do begin @(posedge iCLK); #1; c++; end while (!oENG_GO && c < 50);
        check("pre_rst_go", oENG_GO, 1);
        repeat (5) @(posedge iCLK);
        #1 iRST = 1'b1;
        iREQ = 2'b10;
        d1a = 24'($urandom);
        setData(1, d1a);
        @(posedge iCLK); #1;
        check("mid_rst_go", oENG_GO, 0);
        check("mid_rst_gnt", oGNT, 0);
        check("mid_rst_busy", oBUSY, 0);
        check("mid_rst_data", oENG_DATA, 0);
        check("mid_rst_done", oDONE | oERR, 0);
        @(posedge iCLK); #1;
        iRST = 1'b0;
        addCmd(1, d1a, 0, 0, 0, $urandom_range(1, 30));
        waitDone(1); iREQ = '0;

        // Randomized single commands
        for (int n = 0; n < 12; n++) begin
            int r;
            r = $urandom_range(0, N - 1);
            d = 24'($urandom);
            addCmd(r, d, $urandom_range(0, 2), $urandom_range(0, 1),
                   $urandom_range(0, 2), $urandom_range(1, 30));
            setData(r, d);
            iREQ[r] = 1'b1;
            waitDone(r);
            iREQ[r] = 1'b0;
        end

        repeat (5) @(posedge iCLK); #1;
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_cmd_arbiter.md
Name: i2c_cmd_arbiter

Overview:
Shares one I2C byte-transaction engine (24-bit {slave_addr, sub_addr, data} command, GO/END/ACK handshake) between N_REQ configuration requesters, e.g. the HDMI transmitter setup sequencer and an audio codec setup sequencer. Arbitration is round-robin. The block sequences each command, retries on no-acknowledge and guards against a hung engine with a timeout. Each command returns one done/error pulse to its requester. It sits between the per-device LUT sequencers and the shared I2C engine, in the engine's clock domain.

Parameters:
N_REQ, 2, number of requesters (1..8)
MAX_RETRY, 3, total attempts per command before reporting error (>=1)
TIMEOUT_CYC, 65535, max iCLK cycles from GO to END before aborting
GAP_CYC, 16, idle cycles enforced after each attempt before next GO

Ports:
iCLK  in  1  block clock; engine runs on the same clock
iRST  in  1  synchronous reset, active-high
iREQ  in  N_REQ  per-requester command request level
iREQ_DATA  in  24*N_REQ  requester i command in bits [24i+23:24i]
oGNT  out  N_REQ  one-hot grant; high while requester's command is in flight
oDONE  out  N_REQ  one-cycle completion pulse to granted requester
oERR  out  N_REQ  one-cycle error flag, coincident with oDONE
oBUSY  out  1  high in any state other than IDLE
oENG_DATA  out  24  command to engine, stable while oENG_GO high
oENG_GO  out  1  engine start, held high until iENG_END seen
iENG_END  in  1  engine transfer complete; held high until GO low
iENG_ACK  in  1  sampled with END: 0 = acknowledged, 1 = no-acknowledge

Behaviour:
- Reset, synchronous: all outputs 0. FSM enters IDLE. Round-robin pointer resets to 0. Retry and timeout counters clear. Reset mid-transfer drops oENG_GO on the same edge.
- FSM states: IDLE, ISSUE, WAIT_END, RELEASE, GAP.
- IDLE:
  - iREQ is sampled only in this state.
  - Grant the first set bit at or after the pointer, with wrap-around.
  - Latch that requester's iREQ_DATA into oENG_DATA and set oGNT.
  - Clear the retry counter, then go to ISSUE.
  - With no requests, stay in IDLE.
- ISSUE: oENG_GO <= 1; clear the timeout counter; go to WAIT_END.
- WAIT_END:
  - The timeout counter increments each cycle.
  - iENG_END=1: oENG_GO <= 0. Outcome is ok if iENG_ACK=0, else nack. Go to RELEASE.
  - Counter reaches TIMEOUT_CYC with no END: oENG_GO <= 0, outcome timeout, go to RELEASE.
  - If END and timeout occur in the same cycle, END wins.
- RELEASE: wait for iENG_END=0, then load the gap counter with GAP_CYC and go to GAP. Timeout does not apply in this state.
- GAP: count down to 0, then resolve the outcome:
  - ok: pulse oDONE[g].
  - nack with retry_cnt+1 < MAX_RETRY: increment retry_cnt and return to ISSUE. oENG_DATA and oGNT are unchanged.
  - nack on the final attempt, or timeout (never retried): pulse oDONE[g] and oERR[g] together.
  - On completion: clear oGNT and set pointer = (g+1) mod N_REQ in the same cycle, then go to IDLE.
- Latency: from IDLE with a request, oENG_GO is high 2 cycles later.
- Requester contract:
  - Hold iREQ and data until oDONE.
  - Dropping iREQ mid-transaction is ignored; the command still completes and pulses oDONE.
  - iREQ still high when the FSM returns to IDLE counts as a new request.
- Counter widths: timeout uses $clog2(TIMEOUT_CYC+1), gap uses $clog2(GAP_CYC+1), retry uses $clog2(MAX_RETRY+1).
- GAP_CYC=0 passes through GAP in a single cycle.

Decomposition:
- Shared package i2c_cfg_pkg:
  - FSM state enum.
  - Outcome enum: OK, NACK, TIMEOUT.
  - Constant I2C_CMD_W=24.
  - Command field-slice localparams: slave [23:16], sub [15:8], data [7:0].
- One natural sub-module, rr_arbiter: combinational N_REQ round-robin pick from request vector and pointer, returning a one-hot grant and an index. It is reusable by other shared-resource schedulers.

Test Plan:
- Single requester 0 with data 0x729803; engine ACK=0 after 40 cycles -> GO rises 2 cycles after REQ, oENG_DATA=0x729803, oDONE[0]=1 and oERR[0]=0 exactly once, oGNT returns to 0.
- Both requesters held high continuously after reset -> grants alternate 0,1,0,1 and each receives one oDONE per grant.
- Requester 1 engine returns ACK=1 on every attempt, MAX_RETRY=3 -> exactly 3 GO pulses, each preceded by ≥16 idle cycles, then oDONE[1]=oERR[1]=1.
- NACK on first attempt then ACK=0 -> exactly 2 GO pulses, oDONE[1]=1 with oERR[1]=0, same oENG_DATA on both attempts.
- Engine never raises END, TIMEOUT_CYC=100 -> GO drops 100 cycles after rise, no retry, oERR pulses with oDONE.
- iRST asserted while in WAIT_END -> oENG_GO=0 on next edge, all outputs 0; after release a pending iREQ[1] alone is granted normally.
